// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// One request is in flight at a time; anything presented while Busy is high is dropped.
//
//   state  | meaning
//   S_IDLE | waiting for MemRead/MemWrite; request captured on the accepting edge
//   S_WAIT | latency down-counter running
//   S_RESP | Ready strobe; write commits on the edge leaving this state
module dmem_responder #(
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Error,
   output logic        Busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [31:0]         mem_q [DEPTH];

   logic                req_in;
   logic                req_err;
   logic [ADDR_W-1:0]   req_idx;
   logic                wr_commit;

   assign req_in    = MemRead | MemWrite;
   assign req_idx   = Addr[ADDR_W+1:2];
   assign req_err   = (MemRead & MemWrite) | (|Addr[1:0]) | ((Addr >> (ADDR_W + 2)) != 32'd0);
   assign wr_commit = (state_q == S_RESP) && wr_q && !err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // ReadData is loaded on the edge entering RESP; with zero latency that is the
   // accepting edge itself, so the live address is used instead of the captured one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_in) begin
               rd_d    = MemRead;
               wr_d    = MemWrite;
               err_d   = req_err;
               addr_d  = req_idx;
               wdata_d = WriteData;
               if (LATENCY == 0) begin
                  state_d = S_RESP;
                  if (MemRead && !req_err) begin
                     rdata_d = mem_q[req_idx];
                  end
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = LAT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               if (rd_q && !err_q) begin
                  rdata_d = mem_q[addr_q];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Storage has no reset; the write enable is gated by state, which reset clears.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign ReadData = rdata_q;
   assign Busy     = (state_q != S_IDLE);
   assign Ready    = (state_q == S_RESP);
   assign Error    = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        rd2, wr2, rdy2, err2, busy2;
   logic [31:0] addr2, wd2, rdat2;
   logic        rd0, wr0, rdy0, err0, busy0;
   logic [31:0] addr0, wd0, rdat0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(6), .LATENCY(2)) dut (
      .clk(clk), .reset(rst), .MemRead(rd2), .MemWrite(wr2), .Addr(addr2),
      .WriteData(wd2), .ReadData(rdat2), .Ready(rdy2), .Error(err2), .Busy(busy2)
   );

   dmem_responder #(.ADDR_W(6), .LATENCY(0)) dut0 (
      .clk(clk), .reset(rst), .MemRead(rd0), .MemWrite(wr0), .Addr(addr0),
      .WriteData(wd0), .ReadData(rdat0), .Ready(rdy0), .Error(err0), .Busy(busy0)
   );

   typedef struct {
      bit          sel;      // 0: LATENCY=2 instance, 1: LATENCY=0 instance
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_data; // ReadData seen during the Ready cycle
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         rd0 = r; wr0 = w; addr0 = a; wd0 = d;
      end else begin
         rd2 = r; wr2 = w; addr2 = a; wd2 = d;
      end
   endtask

   // Starts at a negedge with the DUT idle; ends at a negedge with it idle again.
   task automatic run_txn(input int idx, input vec_t v);
      int          lat;
      int          rdy_idx;
      int          pulses;
      logic        e_at;
      logic [31:0] d_at;
      logic        b_first;
      logic        b_after;
      logic        r, e, b;
      logic [31:0] d;
      lat     = v.sel ? 0 : 2;
      rdy_idx = -1;
      pulses  = 0;
      e_at    = 1'b0;
      d_at    = 32'h0;
      b_first = 1'b0;
      b_after = 1'b1;
      drive(v.sel, v.rd, v.wr, v.addr, v.wdata);
      @(posedge clk);
      #1 drive(v.sel, 1'b0, 1'b0, ~v.addr, ~v.wdata);
      for (int i = 0; i < lat + 4; i++) begin
         @(negedge clk);
         r = v.sel ? rdy0  : rdy2;
         e = v.sel ? err0  : err2;
         b = v.sel ? busy0 : busy2;
         d = v.sel ? rdat0 : rdat2;
         if (i == 0) b_first = b;
         if (i == lat + 1) b_after = b;
         if (r) begin
            pulses++;
            if (rdy_idx < 0) begin
               rdy_idx = i;
               e_at    = e;
               d_at    = d;
            end
         end
      end
      chk($sformatf("v%0d ready_cycle", idx), 32'(rdy_idx), 32'(lat));
      chk($sformatf("v%0d ready_pulses", idx), 32'(pulses), 32'd1);
      chk($sformatf("v%0d busy_in_flight", idx), 32'(b_first), 32'd1);
      chk($sformatf("v%0d busy_after_resp", idx), 32'(b_after), 32'd0);
      chk($sformatf("v%0d error", idx), 32'(e_at), 32'(v.exp_err));
      chk($sformatf("v%0d read_data", idx), d_at, v.exp_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      //           sel  rd    wr    addr          wdata         err   data
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h00C0_FFEE, 1'b0, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h00C0_FFEE});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h7777_7777, 1'b1, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h00C0_FFEE});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h00C0_FFEE});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hCAFE_F00D});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_01FC, 32'h0,         1'b1, 32'hCAFE_F00D});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 32'hCAFE_F00D});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_AAAA, 1'b0, 32'hCAFE_F00D});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'hCAFE_F00D});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0000_003C, 32'h1357_2468, 1'b0, 32'h0000_0000});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_003C, 32'h0,         1'b0, 32'h1357_2468});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_003E, 32'h0,         1'b1, 32'h1357_2468});

      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy2), 32'd0);
      chk("reset ready", 32'(rdy2), 32'd0);
      chk("reset error", 32'(err2), 32'd0);
      chk("reset read_data", rdat2, 32'h0);
      chk("reset busy lat0", 32'(busy0), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_txn(i, vecs[i]);

      // Write to 0x24, then hold a write to 0x20 asserted for the whole busy window.
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0024, 32'h9999_9999);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h3333_4444);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rdy2) pulses++;
      end
      chk("busydrop idle", 32'(busy2), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("busydrop pulses", 32'(pulses), 32'd1);
      run_txn(100, '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D});
      run_txn(101, '{1'b0, 1'b1, 1'b0, 32'h0000_0024, 32'h0, 1'b0, 32'h9999_9999});

      // Reset abort during WAIT of a write to 0x04.
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("abort busy before", 32'(busy2), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort busy", 32'(busy2), 32'd0);
      chk("abort ready", 32'(rdy2), 32'd0);
      chk("abort error", 32'(err2), 32'd0);
      chk("abort read_data", rdat2, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_txn(102, '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h0000_AAAA});

      // Zero-latency back-to-back: write, then a read held until the next accepting edge.
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5);
      @(posedge clk);
      #1 drive(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'hFFFF_0000);
      @(negedge clk);
      chk("lat0 wr ready", 32'(rdy0), 32'd1);
      chk("lat0 wr error", 32'(err0), 32'd0);
      @(negedge clk);
      chk("lat0 idle ready", 32'(rdy0), 32'd0);
      chk("lat0 idle busy", 32'(busy0), 32'd0);
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("lat0 rd ready", 32'(rdy0), 32'd1);
      chk("lat0 rd error", 32'(err0), 32'd0);
      chk("lat0 rd data", rdat0, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("lat0 rd done", 32'(rdy0), 32'd0);
      chk("lat0 rd hold", rdat0, 32'hA5A5_A5A5);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
